// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler feeding the CPU PC-select mux (save PC, pick next READY, load PC).
// Optional: define ESCALONADOR_CONTA_TROCAS_EN to add the saturating trocas_total LOAD counter.
module escalonador_round_robin #(
  parameter int NUM_PROC  = 10,
  parameter int QUANTUM   = 16,
  parameter int PROC_SPAN = 300,
  parameter int PC_W      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      num_procs,
  input  logic            enable,
  input  logic [PC_W-1:0] pc_atual,
  input  logic            io_block,
  input  logic            io_done,
  input  logic [3:0]      io_proc,
  input  logic            fim_processo,
  output logic            troca_contexto,
  output logic [PC_W-1:0] pc_proximo,
  output logic [3:0]      processo_atual,
  output logic [4:0]      quantum_restante,
  output logic            ocioso,
  output logic            todos_concluidos
`ifdef ESCALONADOR_CONTA_TROCAS_EN
  ,
  output logic [15:0]     trocas_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SAVE   = 3'd2,
    S_SELECT = 3'd3,
    S_LOAD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  state_t          state_q, state_d;
  logic [3:0]      n_q, n_d;
  logic [3:0]      cursor_q, cursor_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      proc_q, proc_d;
  logic [4:0]      qr_q, qr_d;
  logic [PC_W-1:0] pcn_q, pcn_d;
  logic [PC_W-1:0] cap_pc_q, cap_pc_d;
  logic [1:0]      cap_st_q, cap_st_d;
  logic            idle_q, idle_d;

  // Entry 0 is the BIOS slot and is never written.
  logic [PC_W-1:0] pc_q [0:NUM_PROC];
  logic [PC_W-1:0] pc_d [0:NUM_PROC];
  logic [1:0]      st_q [0:NUM_PROC];
  logic [1:0]      st_d [0:NUM_PROC];

  logic [3:0] n_clamp;
  logic [3:0] cand;
  logic       any_blocked;

  assign n_clamp = (num_procs > 4'(NUM_PROC)) ? 4'(NUM_PROC) : num_procs;
  assign cand    = (cursor_q >= n_q) ? 4'd1 : cursor_q + 4'd1;

  always_comb begin
    any_blocked = 1'b0;
    for (int n = 1; n <= NUM_PROC; n++)
      if (st_q[n] == ST_BLOCKED) any_blocked = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    proc_d   = proc_q;
    qr_d     = qr_q;
    pcn_d    = pcn_q;
    cap_pc_d = cap_pc_q;
    cap_st_d = cap_st_q;
    idle_d   = idle_q;
    pc_d     = pc_q;
    st_d     = st_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_clamp == 4'd0) begin
            state_d = S_DONE;
          end else begin
            for (int n = 1; n <= NUM_PROC; n++) begin
              if (4'(n) <= n_clamp) begin
                pc_d[n] = PC_W'(n * PROC_SPAN);
                st_d[n] = ST_READY;
              end
            end
            n_d      = n_clamp;
            cursor_d = 4'd0;
            cnt_d    = 4'd0;
            state_d  = S_SELECT;
          end
        end
      end

      S_RUN: begin
        if (enable && qr_q != 5'd0) qr_d = qr_q - 5'd1;
        if (fim_processo) begin
          cap_st_d = ST_DONE;
          cap_pc_d = pc_atual;
          state_d  = S_SAVE;
        end else if (io_block) begin
          cap_st_d = ST_BLOCKED;
          cap_pc_d = pc_atual;
          state_d  = S_SAVE;
        end else if (enable && qr_q == 5'd1) begin
          cap_st_d = ST_READY;
          cap_pc_d = pc_atual;
          state_d  = S_SAVE;
        end
      end

      S_SAVE: begin
        pc_d[proc_q] = cap_pc_q;
        st_d[proc_q] = cap_st_q;
        cursor_d     = proc_q;
        proc_d       = 4'd0;
        cnt_d        = 4'd0;
        state_d      = S_SELECT;
      end

      S_SELECT: begin
        if (st_q[cand] == ST_READY) begin
          pcn_d   = pc_q[cand];
          proc_d  = cand;
          qr_d    = 5'(QUANTUM);
          idle_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          cursor_d = cand;
          // A full sweep found nothing: idle while someone waits on I/O, else finished.
          if (cnt_q + 4'd1 >= n_q) begin
            cnt_d = 4'd0;
            if (any_blocked) idle_d  = 1'b1;
            else             state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_LOAD: state_d = S_RUN;

      S_DONE: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase

    // Applied after the SAVE write so a same-cycle completion wins over the block.
    if (io_done && state_q != S_IDLE && state_q != S_DONE) begin
      for (int n = 1; n <= NUM_PROC; n++) begin
        if (4'(n) == io_proc && 4'(n) <= n_q && st_d[n] == ST_BLOCKED)
          st_d[n] = ST_READY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      proc_q   <= '0;
      qr_q     <= '0;
      pcn_q    <= '0;
      cap_pc_q <= '0;
      cap_st_q <= ST_FREE;
      idle_q   <= 1'b0;
      for (int n = 0; n <= NUM_PROC; n++) begin
        pc_q[n] <= '0;
        st_q[n] <= ST_FREE;
      end
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      proc_q   <= proc_d;
      qr_q     <= qr_d;
      pcn_q    <= pcn_d;
      cap_pc_q <= cap_pc_d;
      cap_st_q <= cap_st_d;
      idle_q   <= idle_d;
      for (int n = 0; n <= NUM_PROC; n++) begin
        pc_q[n] <= pc_d[n];
        st_q[n] <= st_d[n];
      end
    end
  end

  assign troca_contexto   = (state_q == S_LOAD);
  assign pc_proximo       = pcn_q;
  assign processo_atual   = proc_q;
  assign quantum_restante = qr_q;
  assign ocioso           = idle_q | (state_q == S_DONE);
  assign todos_concluidos = (state_q == S_DONE);

`ifdef ESCALONADOR_CONTA_TROCAS_EN
  logic [15:0] trocas_q, trocas_d;

  always_comb begin
    trocas_d = trocas_q;
    if (state_q == S_LOAD && trocas_q != 16'hFFFF) trocas_d = trocas_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) trocas_q <= '0;
    else       trocas_q <= trocas_d;
  end

  assign trocas_total = trocas_q;
`endif

endmodule

// File: tb/tb_escalonador_round_robin.sv
// Directed bench for escalonador_round_robin: per-cycle vector table plus corner-case sequences.
module tb_escalonador_round_robin;
  localparam int QT = 4;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  num_procs;
  logic        enable;
  logic [31:0] pc_atual;
  logic        io_block;
  logic        io_done;
  logic [3:0]  io_proc;
  logic        fim_processo;
  logic        troca_contexto;
  logic [31:0] pc_proximo;
  logic [3:0]  processo_atual;
  logic [4:0]  quantum_restante;
  logic        ocioso;
  logic        todos_concluidos;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
  logic [15:0] trocas_total;
`endif

  int checks = 0;
  int errors = 0;

  escalonador_round_robin #(
    .NUM_PROC(10), .QUANTUM(QT), .PROC_SPAN(300), .PC_W(32)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_procs(num_procs),
    .enable(enable), .pc_atual(pc_atual), .io_block(io_block),
    .io_done(io_done), .io_proc(io_proc), .fim_processo(fim_processo),
    .troca_contexto(troca_contexto), .pc_proximo(pc_proximo),
    .processo_atual(processo_atual), .quantum_restante(quantum_restante),
    .ocioso(ocioso), .todos_concluidos(todos_concluidos)
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    , .trocas_total(trocas_total)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, st;
    logic [3:0]  np;
    logic        en;
    logic [31:0] pca;
    logic        iob, iod;
    logic [3:0]  iop;
    logic        fim;
    logic        e_tr;
    logic [31:0] e_pc;
    logic [3:0]  e_pr;
    logic [4:0]  e_qr;
    logic        e_oc, e_dn, cq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int rst, int st, int np, int en, int pca, int iob, int iod,
                              int iop, int fim, int tr, int pc, int pr, int qr, int oc,
                              int dn, int cq);
    vec_t r;
    r.rst = (rst != 0); r.st = (st != 0); r.np = 4'(np); r.en = (en != 0);
    r.pca = 32'(pca); r.iob = (iob != 0); r.iod = (iod != 0); r.iop = 4'(iop);
    r.fim = (fim != 0); r.e_tr = (tr != 0); r.e_pc = 32'(pc); r.e_pr = 4'(pr);
    r.e_qr = 5'(qr); r.e_oc = (oc != 0); r.e_dn = (dn != 0); r.cq = (cq != 0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; start = 1'b0; num_procs = 4'd0; enable = 1'b0; pc_atual = 32'd0;
    io_block = 1'b0; io_done = 1'b0; io_proc = 4'd0; fim_processo = 1'b0;
  endtask

  task automatic wait_troca(input string nm);
    int k;
    k = 0;
    while (!troca_contexto && k < 30) begin
      tick();
      k++;
    end
    chk({nm, "_load_seen"}, 32'(troca_contexto), 32'd1);
  endtask

  task automatic expire(input logic [31:0] pc);
    enable = 1'b1;
    repeat (QT - 1) tick();
    pc_atual = pc;
    tick();
    enable = 1'b0;
    pc_atual = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();

    // Main scenario, N=3, QUANTUM=4. Fields: rst st np en pca iob iod iop fim | tr pc pr qr oc dn cq
    vq.push_back(mk(1,0,0,0,0,  0,0,0,0, 0,0,  0,0,0,0,1));
    vq.push_back(mk(0,1,3,0,0,  0,0,0,0, 0,0,  0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,300,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,300,1,4,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,300,1,3,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,300,1,2,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,300,1,1,0,0,1));
    vq.push_back(mk(0,0,0,1,305,0,0,0,0, 0,300,1,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,300,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,600,2,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,600,2,4,0,0,1));
    vq.push_back(mk(0,0,0,0,610,1,0,0,0, 0,600,2,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,600,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,900,3,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,900,3,4,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,900,3,3,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,900,3,2,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,900,3,1,0,0,1));
    vq.push_back(mk(0,0,0,1,950,0,0,0,0, 0,900,3,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,900,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,305,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,305,1,4,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,305,1,3,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,305,1,2,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,305,1,1,0,0,1));
    vq.push_back(mk(0,0,0,1,320,0,0,0,0, 0,305,1,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,305,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,305,0,0,0,0,1)); // entry 2 blocked: skipped
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,950,3,4,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,1,2,0, 0,950,3,4,0,0,1)); // io_done in LOAD, enable ignored
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,950,3,3,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,950,3,2,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,950,3,1,0,0,1));
    vq.push_back(mk(0,0,0,1,960,0,0,0,0, 0,950,3,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,950,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,320,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,320,1,4,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,320,1,3,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,320,1,2,0,0,1));
    vq.push_back(mk(0,0,0,1,0,  0,0,0,0, 0,320,1,1,0,0,1));
    vq.push_back(mk(0,0,0,1,330,0,0,0,0, 0,320,1,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,320,0,0,0,0,1));
    vq.push_back(mk(0,1,5,1,0,  1,0,0,1, 1,610,2,4,0,0,1)); // RUN-only inputs ignored in SELECT
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,610,2,4,0,0,1));
    vq.push_back(mk(0,0,0,0,620,1,0,0,1, 0,610,2,4,0,0,1)); // fim beats io_block
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,610,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,960,3,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,960,3,4,0,0,1));
    vq.push_back(mk(0,0,0,0,970,0,0,0,1, 0,960,3,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,960,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 1,330,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,330,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,340,0,0,0,1, 0,330,1,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,330,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,330,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,330,0,4,0,0,1));
    vq.push_back(mk(0,0,0,0,0,  0,0,0,0, 0,330,0,0,1,1,0));
    vq.push_back(mk(0,1,3,0,0,  0,0,0,0, 0,330,0,0,1,1,0)); // start ignored in DONE

    foreach (vq[i]) begin
      reset = vq[i].rst; start = vq[i].st; num_procs = vq[i].np; enable = vq[i].en;
      pc_atual = vq[i].pca; io_block = vq[i].iob; io_done = vq[i].iod;
      io_proc = vq[i].iop; fim_processo = vq[i].fim;
      tick();
      chk($sformatf("row%0d_troca", i), 32'(troca_contexto), 32'(vq[i].e_tr));
      chk($sformatf("row%0d_pc", i), pc_proximo, vq[i].e_pc);
      chk($sformatf("row%0d_proc", i), 32'(processo_atual), 32'(vq[i].e_pr));
      if (vq[i].cq) chk($sformatf("row%0d_qr", i), 32'(quantum_restante), 32'(vq[i].e_qr));
      chk($sformatf("row%0d_ocioso", i), 32'(ocioso), 32'(vq[i].e_oc));
      chk($sformatf("row%0d_todos", i), 32'(todos_concluidos), 32'(vq[i].e_dn));
    end
    clear_inputs();

    // num_procs = 0 goes straight to DONE
    do_reset();
    start = 1'b1; num_procs = 4'd0;
    tick();
    start = 1'b0;
    chk("n0_todos", 32'(todos_concluidos), 32'd1);
    chk("n0_ocioso", 32'(ocioso), 32'd1);
    chk("n0_troca", 32'(troca_contexto), 32'd0);
    tick();
    chk("n0_hold", 32'(todos_concluidos), 32'd1);

    // Only non-DONE process blocks: idle sweep, invalid io_done ignored, valid one resumes it
    do_reset();
    start = 1'b1; num_procs = 4'd2;
    tick();
    start = 1'b0;
    wait_troca("blk_p1");
    chk("blk_p1_pc", pc_proximo, 32'd300);
    tick();
    fim_processo = 1'b1; pc_atual = 32'd310;
    tick();
    fim_processo = 1'b0;
    wait_troca("blk_p2");
    chk("blk_p2_pc", pc_proximo, 32'd600);
    tick();
    io_block = 1'b1; pc_atual = 32'd615;
    tick();
    io_block = 1'b0;
    begin
      int k;
      k = 0;
      while (!ocioso && k < 20) begin tick(); k++; end
    end
    chk("blk_ocioso", 32'(ocioso), 32'd1);
    chk("blk_proc0", 32'(processo_atual), 32'd0);
    chk("blk_not_done", 32'(todos_concluidos), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      io_done = 1'b1;
      io_proc = 4'd0; tick(); seen |= troca_contexto;
      io_proc = 4'd5; tick(); seen |= troca_contexto;
      io_proc = 4'd1; tick(); seen |= troca_contexto;
      io_done = 1'b0;
      repeat (5) begin tick(); seen |= troca_contexto; end
      chk("blk_bad_iodone_ignored", 32'(seen), 32'd0);
      chk("blk_still_ocioso", 32'(ocioso), 32'd1);
    end
    io_done = 1'b1; io_proc = 4'd2;
    tick();
    io_done = 1'b0; io_proc = 4'd0;
    wait_troca("blk_resume");
    chk("blk_resume_pc", pc_proximo, 32'd615);
    chk("blk_resume_proc", 32'(processo_atual), 32'd2);
    chk("blk_resume_ocioso", 32'(ocioso), 32'd0);
    chk("blk_resume_qr", 32'(quantum_restante), 32'(QT));

    // num_procs = 15 clamps to 10: walk all entries, then wrap to 1 with its saved PC
    do_reset();
    start = 1'b1; num_procs = 4'd15;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
`ifdef ESCALONADOR_CONTA_TROCAS_EN
      if (n == 6) chk("cnt_after5", 32'(trocas_total), 32'd5);
`endif
      wait_troca($sformatf("clamp_p%0d", n));
      chk($sformatf("clamp_p%0d_pc", n), pc_proximo, 32'(n * 300));
      chk($sformatf("clamp_p%0d_proc", n), 32'(processo_atual), 32'(n));
      tick();
      expire(32'(n * 300 + 7));
    end
    wait_troca("clamp_wrap");
    chk("clamp_wrap_proc", 32'(processo_atual), 32'd1);
    chk("clamp_wrap_pc", pc_proximo, 32'd307);

    // Reset while in SELECT
    tick();
    expire(32'd500);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstsel_troca", 32'(troca_contexto), 32'd0);
    chk("rstsel_pc", pc_proximo, 32'd0);
    chk("rstsel_proc", 32'(processo_atual), 32'd0);
    chk("rstsel_qr", 32'(quantum_restante), 32'd0);
    chk("rstsel_ocioso", 32'(ocioso), 32'd0);
    chk("rstsel_todos", 32'(todos_concluidos), 32'd0);
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    chk("cnt_reset", 32'(trocas_total), 32'd0);
`endif
    tick();
    chk("rstsel_idle_troca", 32'(troca_contexto), 32'd0);
    start = 1'b1; num_procs = 4'd3;
    tick();
    start = 1'b0;
    tick();
    chk("restart_troca", 32'(troca_contexto), 32'd1);
    chk("restart_pc", pc_proximo, 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/escalonador_round_robin.md
Name: escalonador_round_robin

Overview:
- Round-robin process scheduler that sits directly upstream of the CPU PC-select logic.
- Tracks up to NUM_PROC user processes and their saved PCs and states.
- Counts each process's quantum in retired instructions.
- On quantum expiry, I/O block or process end, it saves the running PC, picks the next READY process and drives troca_contexto / pc_proximo into the PC mux.

Parameters:
NUM_PROC, 10, maximum number of processes (index 1..NUM_PROC; 0 = BIOS/none)
QUANTUM, 16, instructions per time slice
PROC_SPAN, 300, PC spacing of process images; process n starts at n*PROC_SPAN
PC_W, 32, PC width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  BIOS finished; begin scheduling (sampled in IDLE only)
num_procs  in  4  number of processes to run
enable  in  1  one instruction retired this cycle (quantum tick)
pc_atual  in  PC_W  PC of the running instruction
io_block  in  1  running process blocks on I/O
io_done  in  1  I/O completed for process io_proc
io_proc  in  4  process index for io_done
fim_processo  in  1  running process terminated
troca_contexto  out  1  load pc_proximo into PC this cycle
pc_proximo  out  PC_W  PC of selected process
processo_atual  out  4  index of running process (0 = none)
quantum_restante  out  5  ticks left in current slice
ocioso  out  1  no READY process available
todos_concluidos  out  1  every process is DONE

Behaviour:
- Reset, synchronous, priority over everything:
  - FSM goes to IDLE; all table entries become FREE with saved PC 0.
  - All outputs are 0; quantum_restante is 0.
  - A reset mid-switch aborts the switch with no partial table write.
- Table: per entry, a PC_W-bit saved PC and a 2-bit state: FREE=0, READY=1, BLOCKED=2, DONE=3.
- num_procs values above NUM_PROC are clamped to NUM_PROC (call the result N).
- FSM states: IDLE, RUN, SAVE, SELECT, LOAD, DONE.
- IDLE:
  - On start with N=0: go to DONE.
  - On start with N>0: entries 1..N become READY with PC n*PROC_SPAN, all written in the same cycle. Set cursor=0 and go to SELECT.
- RUN:
  - Each enable decrements quantum_restante.
  - Event priority: fim_processo > io_block > expiry. Expiry is enable while quantum_restante==1.
  - On an event, capture pc_atual, then go to SAVE.
  - enable with no event only counts.
- SAVE (1 cycle): write the captured PC and the new state into entry processo_atual.
  - fim_processo writes DONE; io_block writes BLOCKED; expiry writes READY.
  - cursor = processo_atual.
- SELECT:
  - Examine one candidate per cycle: cursor+1, wrapping from N to 1.
  - READY candidate: go to LOAD.
  - After N candidates with none READY:
    - If any entry is BLOCKED: stay in SELECT and keep sweeping, with ocioso=1 and processo_atual=0.
    - Otherwise go to DONE.
- LOAD (1 cycle):
  - troca_contexto=1, pc_proximo=saved PC, processo_atual=index.
  - quantum_restante=QUANTUM; next state RUN.
  - troca_contexto is high only in LOAD.
- DONE: todos_concluidos=1, ocioso=1, processo_atual=0. Held until reset.
- Latency:
  - Event seen at edge t: SAVE in t+1, first SELECT in t+2, LOAD in t+3 if the first candidate is READY.
  - Each non-READY candidate adds +1 cycle.
  - start to LOAD: 2 cycles.
- io_done:
  - Any state except IDLE/DONE.
  - Sets entry io_proc BLOCKED->READY.
  - Ignored if io_proc is 0, above N, or the entry is not BLOCKED.
  - If the same cycle's SAVE writes that entry as BLOCKED, the final state is READY (completion wins).
  - io_done landing in SELECT is seen by the next candidate check.
- enable, io_block and fim_processo are ignored outside RUN.
- start is ignored outside IDLE.
- pc_proximo holds its value between switches.
- Single process (N=1) with expiry: reselects itself; troca_contexto pulses and pc_proximo = saved PC.

Optional Feature:
- Macro: ESCALONADOR_CONTA_TROCAS_EN.
- When defined:
  - Adds output trocas_total [15:0], counting LOAD cycles.
  - Saturates at 16'hFFFF; cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with num_procs=3, QUANTUM=4 -> 2 cycles later troca_contexto=1 for one cycle, pc_proximo=300, processo_atual=1, quantum_restante=4.
- 4 enables with pc_atual=305 on the last -> 3 cycles later LOAD: pc_proximo=600, processo_atual=2; entry 1 is READY with PC 305.
- io_block in process 2 at pc_atual=610 -> switch to 3 (pc 900); then expiry -> process 1 (pc 305); entry 2 is skipped (adds 1 cycle); io_done io_proc=2 -> next expiry of 1 selects 2 at pc 610.
- io_block on the only non-DONE process -> ocioso=1, processo_atual=0; io_done 2 cycles later -> LOAD with that PC, ocioso=0.
- fim_processo on every process in turn -> DONE: todos_concluidos=1, troca_contexto stays 0; start with num_procs=0 -> DONE directly; num_procs=15 -> 10 entries initialised (PCs 300..3000).
- Reset asserted during SELECT -> next cycle all outputs 0, IDLE; with ESCALONADOR_CONTA_TROCAS_EN, trocas_total counts 5 after 5 switches and resets to 0.
